jtag_tap_core: RTL
==================

# jtag_tap_core

Parametrised JTAG TAP core: the 16-state IEEE 1149.1 TAP state machine plus an instruction register, instruction decode and three data registers (BYPASS, IDCODE, USER). It drives TDO directly. It sits between the board JTAG pins and on-chip debug/config logic. It extends the plain TAP state tracker with configurable IR width, a configurable IDCODE value and a parallel-load/parallel-update USER register.

## Interface
Parameters:
- IR_WIDTH, 4: instruction register width, ≥ 2.
- IDCODE_VALUE, 32'h1234_5001: value captured into IDCODE DR. Bit 0 must be 1.
- USER_WIDTH, 8: USER DR width, ≥ 1.
- IDCODE_INSTR, 1: IR code selecting IDCODE. Loaded at reset.
- USER_INSTR, 2: IR code selecting USER.
- BYPASS is the all-ones IR code. Any code not listed selects BYPASS.

Ports:
- TCK  in  1  TAP clock. All state changes happen on its rising edge.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- TDO_en  out  1  high only in DR_SHIFT or IR_SHIFT.
- state_out  out  4  current TAP state code.
- ir_out  out  IR_WIDTH  active instruction.
- user_dr_in  in  USER_WIDTH  parallel value captured into USER DR.
- user_dr_out  out  USER_WIDTH  last updated USER value.
- user_update  out  1  one-cycle strobe marking that user_dr_out has been updated.

## Operation
- State codes:
  - RESET 0, IDLE 1, DR_SELECT 2, DR_CAPTURE 3, DR_SHIFT 4, DR_EXIT1 5, DR_PAUSE 6, DR_EXIT2 7, DR_UPDATE 8.
  - IR_SELECT 9, IR_CAPTURE A, IR_SHIFT B, IR_EXIT1 C, IR_PAUSE D, IR_EXIT2 E, IR_UPDATE F.
- Transitions (TMS=1 / TMS=0):
  - RESET→RESET/IDLE; IDLE→DR_SELECT/IDLE.
  - DR_SELECT→IR_SELECT/DR_CAPTURE; CAPTURE→EXIT1/SHIFT; SHIFT→EXIT1/SHIFT.
  - EXIT1→UPDATE/PAUSE; PAUSE→EXIT2/PAUSE; EXIT2→UPDATE/SHIFT. The same pattern applies on the IR side.
  - IR_SELECT→RESET/IR_CAPTURE; DR_UPDATE and IR_UPDATE→DR_SELECT/IDLE.
- Rule for register actions: an action "in state S" takes effect at the rising TCK edge at which current state is S.
- IR:
  - IR_CAPTURE: ir_shift ← {0…0,2'b01}.
  - IR_SHIFT: ir_shift ← {TDI, ir_shift[IR_WIDTH-1:1]}.
  - IR_UPDATE: ir_out ← ir_shift.
  - RESET: ir_out ← IDCODE_INSTR.
- DR selection is decoded from ir_out:
  - Capture:
    - BYPASS bit ← 0.
    - idcode_shift ← IDCODE_VALUE.
    - user_shift ← user_dr_in.
  - Shift: only the selected register shifts right, with TDI entering at its MSB. BYPASS is a single flop loaded from TDI.
  - DR_UPDATE with USER selected: user_dr_out ← user_shift and user_update ← 1. In every other cycle user_update ← 0.
- TDO (combinational):
  - In IR_SHIFT: ir_shift[0].
  - In DR_SHIFT: LSB of the selected DR.
  - Otherwise 0, with TDO_en=0.
- Five consecutive TMS=1 edges reach RESET from any state.

## Timing
- TRST high:
  - Immediately, without a clock edge: state RESET, ir_out=IDCODE_INSTR, user_dr_out=0, user_update=0.
  - Shift registers clear to 0, so TDO=0 and TDO_en=0.
- After TRST is released, the first TCK edge evaluates TMS from RESET.
- Shift latency:
  - BYPASS: TDI appears on TDO 1 edge later.
  - IDCODE: the first bit out is IDCODE_VALUE[0], valid throughout the first DR_SHIFT cycle. 32 shift edges empty the register.
- Shift counts: exactly N shift edges move N bits. The edge leaving CAPTURE does not shift.
- The edge leaving DR_SHIFT (to EXIT1) still shifts.
- PAUSE and EXIT states hold shift register contents.
- Updates:
  - user_update is high for exactly one TCK cycle, the cycle after the DR_UPDATE edge.
  - ir_out changes only on IR_UPDATE or RESET.
  - An aborted scan (reaching RESET via TMS) leaves user_dr_out unchanged and forces ir_out=IDCODE_INSTR.
- TRST asserted mid-shift: ir_shift and the DR shift registers clear, and no update occurs.

## Test plan
- Reset: pulse TRST with TCK idle → state_out=0, ir_out=1, user_dr_out=0, TDO_en=0. From DR_PAUSE, five TMS=1 edges → state_out=0.
- IDCODE after reset: TMS 0,1,0,0 → DR_SHIFT. Shift 32 bits TDI=0 → TDO sequence equals 32'h1234_5001 LSB first, TDO_en=1.
- IR capture/load:
  - Enter IR_SHIFT and shift in 4'b1111 → bits out are 1,0,0,0.
  - After IR_UPDATE → ir_out=4'hF.
  - A DR shift of pattern 1,0,1,1 emerges delayed by exactly 1 edge.
- USER write/read:
  - Set user_dr_in=8'hA5, load USER_INSTR and shift in 8'h3C.
  - TDO emits A5 LSB first.
  - After DR_UPDATE → user_dr_out=8'h3C, user_update high for one cycle.
- Unknown IR code 4'h7 → behaves as BYPASS (1-bit delay). Walk every state transition with both TMS values; state_out matches the table.
- TRST mid-USER-shift after 4 bits → state RESET, user_dr_out keeps its prior value, user_update stays 0.

Source files
------------

// File: rtl/jtag_tap_core.sv
// ---------------------------------------------------------------------------
// jtag_tap_core
//
// Purpose:
//   IEEE 1149.1 TAP controller with an instruction register, instruction
//   decode and three data registers (BYPASS, IDCODE, USER).  TDO is driven
//   combinationally from the LSB of whichever register is currently shifting.
//   The USER register can be loaded in parallel from user_dr_in and its
//   shifted-in value is published on user_dr_out at DR_UPDATE.
//
// Ports:
//   TCK          in   TAP clock; every state change happens on its rising edge
//   TRST         in   asynchronous active-high reset
//   TMS          in   mode select steering the TAP state machine
//   TDI          in   serial data in
//   TDO          out  serial data out (0 outside the shift states)
//   TDO_en       out  high only in DR_SHIFT or IR_SHIFT
//   state_out    out  current TAP state code (4 bits)
//   ir_out       out  active instruction
//   user_dr_in   in   parallel value captured into the USER register
//   user_dr_out  out  last updated USER value
//   user_update  out  one-cycle strobe after a USER update
// ---------------------------------------------------------------------------
module jtag_tap_core #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001,
  parameter int          USER_WIDTH   = 8,
  parameter int          IDCODE_INSTR = 1,
  parameter int          USER_INSTR   = 2
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  TDO_en,
  output logic [3:0]            state_out,
  output logic [IR_WIDTH-1:0]   ir_out,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_update
);

  typedef enum logic [3:0] {
    RESET      = 4'h0,
    IDLE       = 4'h1,
    DR_SELECT  = 4'h2,
    DR_CAPTURE = 4'h3,
    DR_SHIFT   = 4'h4,
    DR_EXIT1   = 4'h5,
    DR_PAUSE   = 4'h6,
    DR_EXIT2   = 4'h7,
    DR_UPDATE  = 4'h8,
    IR_SELECT  = 4'h9,
    IR_CAPTURE = 4'hA,
    IR_SHIFT   = 4'hB,
    IR_EXIT1   = 4'hC,
    IR_PAUSE   = 4'hD,
    IR_EXIT2   = 4'hE,
    IR_UPDATE  = 4'hF
  } tapState_e;

  localparam logic [IR_WIDTH-1:0] IDCODE_CODE    = IR_WIDTH'(IDCODE_INSTR);
  localparam logic [IR_WIDTH-1:0] USER_CODE      = IR_WIDTH'(USER_INSTR);
  // Fixed IR capture pattern: ...0001, so the first bit out is always 1.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(1);

  tapState_e             state_q, state_d;
  logic [IR_WIDTH-1:0]   irShift_q;
  logic [IR_WIDTH-1:0]   ir_q;
  logic                  bypass_q;
  logic [31:0]           idcodeShift_q;
  logic [USER_WIDTH-1:0] userShift_q;
  logic [USER_WIDTH-1:0] userShifted;
  logic [USER_WIDTH-1:0] userOut_q;
  logic                  userUpdate_q;
  logic                  selIdcode;
  logic                  selUser;

  // Instruction decode; every code other than IDCODE or USER means BYPASS.
  assign selIdcode = (ir_q == IDCODE_CODE);
  assign selUser   = !selIdcode && (ir_q == USER_CODE);

  // TAP state register.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) state_q <= RESET;
    else      state_q <= state_d;
  end

  // TAP next-state logic (standard 16-state graph driven by TMS).
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:      state_d = TMS ? RESET     : IDLE;
      IDLE:       state_d = TMS ? DR_SELECT : IDLE;
      DR_SELECT:  state_d = TMS ? IR_SELECT : DR_CAPTURE;
      DR_CAPTURE: state_d = TMS ? DR_EXIT1  : DR_SHIFT;
      DR_SHIFT:   state_d = TMS ? DR_EXIT1  : DR_SHIFT;
      DR_EXIT1:   state_d = TMS ? DR_UPDATE : DR_PAUSE;
      DR_PAUSE:   state_d = TMS ? DR_EXIT2  : DR_PAUSE;
      DR_EXIT2:   state_d = TMS ? DR_UPDATE : DR_SHIFT;
      DR_UPDATE:  state_d = TMS ? DR_SELECT : IDLE;
      IR_SELECT:  state_d = TMS ? RESET     : IR_CAPTURE;
      IR_CAPTURE: state_d = TMS ? IR_EXIT1  : IR_SHIFT;
      IR_SHIFT:   state_d = TMS ? IR_EXIT1  : IR_SHIFT;
      IR_EXIT1:   state_d = TMS ? IR_UPDATE : IR_PAUSE;
      IR_PAUSE:   state_d = TMS ? IR_EXIT2  : IR_PAUSE;
      IR_EXIT2:   state_d = TMS ? IR_UPDATE : IR_SHIFT;
      IR_UPDATE:  state_d = TMS ? DR_SELECT : IDLE;
      default:    state_d = RESET;
    endcase
  end

  // Instruction shift register and active instruction.  A TMS-driven
  // RESET forces IDCODE back in, just like TRST does.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      irShift_q <= '0;
      ir_q      <= IDCODE_CODE;
    end else begin
      case (state_q)
        IR_CAPTURE: irShift_q <= IR_CAPTURE_VAL;
        IR_SHIFT:   irShift_q <= {TDI, irShift_q[IR_WIDTH-1:1]};
        IR_UPDATE:  ir_q      <= irShift_q;
        RESET:      ir_q      <= IDCODE_CODE;
        default:    ;
      endcase
    end
  end

  // USER shift step written generically so a one-bit USER register works.
  always_comb begin
    userShifted                 = userShift_q >> 1;
    userShifted[USER_WIDTH-1]   = TDI;
  end

  // Data registers: all capture together, only the selected one shifts.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_q      <= 1'b0;
      idcodeShift_q <= '0;
      userShift_q   <= '0;
    end else begin
      if (state_q == DR_CAPTURE) begin
        bypass_q      <= 1'b0;
        idcodeShift_q <= IDCODE_VALUE;
        userShift_q   <= user_dr_in;
      end else if (state_q == DR_SHIFT) begin
        if (selIdcode)    idcodeShift_q <= {TDI, idcodeShift_q[31:1]};
        else if (selUser) userShift_q   <= userShifted;
        else              bypass_q      <= TDI;
      end
    end
  end

  // USER parallel output and its update strobe; the strobe is cleared on
  // every edge that is not a USER DR_UPDATE, giving a one-cycle pulse.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      userOut_q    <= '0;
      userUpdate_q <= 1'b0;
    end else begin
      userUpdate_q <= 1'b0;
      if (state_q == DR_UPDATE && selUser) begin
        userOut_q    <= userShift_q;
        userUpdate_q <= 1'b1;
      end
    end
  end

  // Serial output mux: LSB of whatever is shifting, otherwise quiet.
  always_comb begin
    TDO    = 1'b0;
    TDO_en = 1'b0;
    if (state_q == IR_SHIFT) begin
      TDO_en = 1'b1;
      TDO    = irShift_q[0];
    end else if (state_q == DR_SHIFT) begin
      TDO_en = 1'b1;
      if (selIdcode)    TDO = idcodeShift_q[0];
      else if (selUser) TDO = userShift_q[0];
      else              TDO = bypass_q;
    end
  end

  assign state_out   = state_q;
  assign ir_out      = ir_q;
  assign user_dr_out = userOut_q;
  assign user_update = userUpdate_q;

endmodule
